// File: rtl/dma_rcd_beat_buffer.sv
// rtl/dma_rcd_beat_buffer.sv - elastic beat FIFO on the DMA read-completion path with per-transfer beat tagging
// Optional feature: define DMA_RCD_HWM_EN to add the hwm (occupancy high-water mark) output.
module dma_rcd_beat_buffer #(
  parameter int DEPTH      = 8,
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 16,
  parameter int BEAT_BYTES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_dpram_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [LEN_W-1:0]         in_length,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_dpram_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [LEN_W-1:0]         out_length,
  output logic [LEN_W-1:0]         out_beat_idx,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow_err
`ifdef DMA_RCD_HWM_EN
  ,
  output logic [$clog2(DEPTH):0]   hwm
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Number of beats in a transfer of len bytes; a zero-length transfer still carries one beat.
  function automatic logic [LEN_W:0] beatsOf(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] n;
    n = ({1'b0, len} + (LEN_W+1)'(BEAT_BYTES - 1)) / (LEN_W+1)'(BEAT_BYTES);
    if (n == '0) n = (LEN_W+1)'(1);
    return n;
  endfunction

  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [LEN_W-1:0]  lenMem  [DEPTH];

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [LEN_W-1:0] beatCnt;
  logic [LEN_W-1:0] inBeatCnt;
  logic [LEN_W-1:0] inLenHold;
  logic [LEN_W-1:0] inEffLen;
  logic             inLastBeat;
  logic             doPush;
  logic             doPop;

  assign in_ready  = (occupancy != CNT_W'(DEPTH));
  assign out_valid = (occupancy != '0);
  assign doPush    = in_valid && in_ready;
  assign doPop     = out_valid && out_ready;

  // Length is captured on the first beat of a transfer and reused for the rest of its beats.
  assign inEffLen   = (inBeatCnt == '0) ? in_length : inLenHold;
  assign inLastBeat = ({1'b0, inBeatCnt} == (beatsOf(inEffLen) - (LEN_W+1)'(1)));

  assign out_dpram_addr = addrMem[rdPtr];
  assign out_data       = dataMem[rdPtr];
  assign out_length     = lenMem[rdPtr];
  assign out_beat_idx   = beatCnt;
  assign out_last       = ({1'b0, beatCnt} == (beatsOf(out_length) - (LEN_W+1)'(1)));

  // Payload storage; never reset, only the pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (doPush && !flush && !rst) begin
      addrMem[wrPtr] <= in_dpram_addr;
      dataMem[wrPtr] <= in_data;
      lenMem[wrPtr]  <= inEffLen;
    end
  end

  // Pointers, occupancy and both beat trackers; flush behaves like reset for these.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
      beatCnt   <= '0;
      inBeatCnt <= '0;
      inLenHold <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_W'(1);
        if (inBeatCnt == '0) inLenHold <= in_length;
        if (inLastBeat) inBeatCnt <= '0;
        else            inBeatCnt <= inBeatCnt + LEN_W'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_W'(1);
        if (out_last) beatCnt <= '0;
        else          beatCnt <= beatCnt + LEN_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Sticky record of a producer pushing into a full buffer; survives flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err <= 1'b0;
    end else if (in_valid && !in_ready && !flush) begin
      overflow_err <= 1'b1;
    end
  end

`ifdef DMA_RCD_HWM_EN
  // Track the largest occupancy seen since the last reset or flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hwm <= '0;
    end else if (occupancy > hwm) begin
      hwm <= occupancy;
    end
  end
`endif

endmodule
